// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter between fetch and load-store paths
module mem_port_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);
    localparam int SW = $clog2(MAX_D_BURST + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_i;
    logic          drop;
    logic [SW-1:0] d_streak;
    logic          grant_i;
    logic          grant_d;
    logic          complete;
    logic          flush_hit;
    logic          suppress;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                // Fetch only overrides data once the data streak has saturated
                if (i_req && (!d_req || d_streak == SW'(MAX_D_BURST))) begin
                    grant_i   = 1'b1;
                    state_nxt = REQ;
                end else if (d_req) begin
                    grant_d   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (m_ready) begin
                    if (m_rvalid) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        flush_hit = i_flush && owner_i && (state != IDLE);
        suppress  = drop || flush_hit;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            owner_i  <= 1'b0;
            drop     <= 1'b0;
            d_streak <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_gnt    <= grant_i;
            d_gnt    <= grant_d;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            if (grant_i) begin
                owner_i  <= 1'b1;
                d_streak <= '0;
                m_req    <= 1'b1;
                m_we     <= 1'b0;
                m_addr   <= i_addr;
                m_wdata  <= '0;
                m_wstrb  <= '0;
            end else if (grant_d) begin
                owner_i  <= 1'b0;
                if (d_streak != SW'(MAX_D_BURST)) d_streak <= d_streak + SW'(1);
                m_req    <= 1'b1;
                m_we     <= d_we;
                m_addr   <= d_addr;
                m_wdata  <= d_wdata;
                m_wstrb  <= d_wstrb;
            end else if (state == REQ && m_ready) begin
                m_req <= 1'b0;
            end

            // A squashed fetch still runs to completion on the memory side
            if (complete) begin
                drop <= 1'b0;
                if (owner_i) begin
                    if (!suppress) begin
                        i_rvalid <= 1'b1;
                        i_rdata  <= m_rdata;
                    end
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= m_rdata;
                end
            end else if (flush_hit) begin
                drop <= 1'b1;
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch path (icache refill / fetch) and the load-store unit. It keeps at most one memory transaction in flight, registers the winning request onto the port, and routes the response back to its owner. Fetch responses are squashed on a branch/jump redirect. The block sits between the core (fetch and load-store units) and the memory/bus interface.

## Interface
- ADDR_W, 20, address width; matches the 20-bit PC.
- DATA_W, 32, data width.
- MAX_D_BURST, 4, consecutive data grants allowed before a pending fetch must win.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- i_req  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch address.
- i_flush  in  1  redirect; the in-flight fetch response is discarded.
- i_gnt  out  1  one-cycle pulse: fetch request captured.
- i_rvalid  out  1  one-cycle pulse: fetch data valid.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  load/store address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt  out  1  one-cycle pulse: data request captured.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  DATA_W  load data.
- m_req  out  1  memory request; held until accepted.
- m_we, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/DATA_W/4  registered request fields.
- m_ready  in  1  memory accepts the request when m_req & m_ready.
- m_rvalid  in  1  memory response (read data or write ack).
- m_rdata  in  DATA_W  memory read data.

## Operation
- FSM states are IDLE, REQ, WAIT. The register owner (I/D) records the winner. The register drop marks a squashed fetch.
- **IDLE arbitration:**
  - If d_req and i_req are both high and d_streak == MAX_D_BURST, I wins.
  - Otherwise, if d_req is high, D wins.
  - Otherwise, if i_req is high, I wins.
  - Otherwise, stay in IDLE.
- **On a win:**
  - Capture the winner's fields into the m_* registers. Fetch requests use m_we=0 and m_wstrb=0.
  - Set m_req=1, pulse the winner's gnt, and go to REQ.
- **d_streak bookkeeping:**
  - Increments on a D grant, saturating at MAX_D_BURST.
  - Clears to 0 on any I grant.
- **REQ:**
  - Hold m_req and all m_* fields stable until m_ready.
  - On m_ready, drop m_req.
  - If m_rvalid is also high in that same cycle, complete immediately. Otherwise go to WAIT.
- **WAIT:** on m_rvalid, complete.
- **Complete:**
  - Register m_rdata into the owner's rdata and pulse the owner's rvalid.
  - Exception: the I response is suppressed when drop is set. In that case i_rdata is not updated.
  - Clear drop and go to IDLE.
- **Flush:**
  - i_flush while owner==I in REQ or WAIT sets drop. The transaction still runs to completion, because m_req is never retracted.
  - i_flush in IDLE, or while owner==D, has no effect.
  - i_flush in the same cycle as completion suppresses that response.
- Requesters hold req and their fields stable until they see gnt, then deassert or present the next request. The arbiter ignores req outside IDLE.
- m_rvalid seen in IDLE is ignored.

## Timing
- **Reset** (asynchronous assertion, synchronous release):
  - State IDLE, owner=D, drop=0, d_streak=0.
  - All outputs 0: m_req, m_* fields, gnts, rvalids, rdata.
- **Reset mid-transaction:** m_req drops immediately and the transaction is abandoned. The memory side is reset by the same resetn.
- **Request to grant:** req high in cycle 0 (IDLE) gives gnt=1 and m_req=1 in cycle 1.
- **Accept/response:** if m_ready is high in cycle k and m_rvalid in cycle j ≥ k, rvalid and rdata are visible in cycle j+1, and the FSM is in IDLE in cycle j+1.
- **Back-to-back:** a new arbitration can happen in cycle j+1, so its gnt appears in j+2. Minimum turnaround is 2 cycles per transaction (m_ready and m_rvalid in the same cycle).
- gnt and rvalid are always single-cycle pulses. At most one gnt and at most one rvalid are high in any cycle.

## Test plan
- **Single fetch:** i_req=1, i_addr=0x00040, memory accepts in 1 cycle and responds 2 cycles later with 0x00000013.
  - i_gnt in cycle 1, m_addr=0x00040, m_we=0.
  - i_rvalid=1, i_rdata=0x00000013 exactly one cycle after m_rvalid; no d_* activity.
- **Store:** d_req=1, d_we=1, d_addr=0x01000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011.
  - m_* fields match the inputs and stay stable while m_ready is held low for 3 cycles.
  - d_rvalid pulses once after m_rvalid.
- **Contention/fairness:** i_req and d_req held high continuously, with MAX_D_BURST=4.
  - Grant order is D,D,D,D,I,D,D,D,D,I, …; d_streak is 0 after each I grant.
- **Flush:** fetch granted to 0x00100, i_flush pulsed in WAIT, memory returns 0xAAAAAAAA.
  - No i_rvalid and i_rdata unchanged.
  - A following fetch to 0x00200 returns its data normally.
- **Same-cycle accept+response:** m_ready=1 and m_rvalid=1 in the first REQ cycle.
  - Response delivered the next cycle.
  - A pending d_req is granted one cycle after that (2-cycle turnaround).
- **Reset mid-operation:** resetn low while in WAIT for D.
  - All outputs 0 immediately.
  - After release: IDLE, no spurious d_rvalid even if m_rvalid arrives, and a fresh i_req is granted normally.
